// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - RV32I branch resolution stage with 2-bit BHT prediction
//
// Resolves B-type branches one cycle after they are presented by execute,
// reports the resolved next PC and whether the carried prediction was wrong,
// and keeps a table of 2-bit saturating counters that fetch reads for a
// taken/not-taken guess.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   fetch_pc, fetch_imm     fetch-side PC and sign-extended B-immediate
//   pred_taken              combinational: MSB of the counter indexed by fetch_pc
//   pred_target             combinational: fetch_pc + fetch_imm
//   ex_valid, ex_flush      a branch is in execute / squash it (flush wins)
//   ex_funct3               branch condition
//   ex_rs1, ex_rs2          operands
//   ex_pc, ex_imm           branch PC and immediate
//   ex_pred_taken           prediction carried with the instruction
//   res_valid               registered: resolution reported this cycle
//   res_taken               registered: branch was taken
//   res_next_pc             registered: resolved next PC
//   mispredict              registered: taken differs from carried prediction
//   misaligned              registered: taken target not word aligned
//   illegal                 registered: funct3 is 010 or 011
//   br_count, mp_count      saturating resolved-branch / mispredict counters

module branch_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic [XLEN-1:0]  fetch_imm,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_flush,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    output logic             res_valid,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_next_pc,
    output logic             mispredict,
    output logic             misaligned,
    output logic             illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_STRONG_T = 2'b11;
    localparam logic [1:0] CNT_STRONG_NT = 2'b00;

    logic [1:0] bht [BHT_ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side prediction. Reads the table as it stands before any
    // resolve edge in this cycle; there is deliberately no bypass.
    // ------------------------------------------------------------------
    logic [IDX-1:0] fetch_idx;

    assign fetch_idx   = fetch_pc[IDX+1:2];
    assign pred_taken  = bht[fetch_idx][1];
    assign pred_target = fetch_pc + fetch_imm;

    // ------------------------------------------------------------------
    // Execute-side condition evaluation
    // ------------------------------------------------------------------
    logic            accept;
    logic            legal;
    logic            is_eq;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            cond;
    logic            taken_c;
    logic            mispredict_c;
    logic            misaligned_c;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc_c;
    logic [IDX-1:0]  ex_idx;

    assign accept      = ex_valid & ~ex_flush;
    assign legal       = ~((ex_funct3 == 3'b010) || (ex_funct3 == 3'b011));
    assign is_eq       = (ex_rs1 == ex_rs2);
    assign lt_signed   = ($signed(ex_rs1) < $signed(ex_rs2));
    assign lt_unsigned = (ex_rs1 < ex_rs2);
    assign ex_idx      = ex_pc[IDX+1:2];

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            F3_BEQ:  cond = is_eq;
            F3_BNE:  cond = ~is_eq;
            F3_BLT:  cond = lt_signed;
            F3_BGE:  cond = ~lt_signed;
            F3_BLTU: cond = lt_unsigned;
            F3_BGEU: cond = ~lt_unsigned;
            default: cond = 1'b0;
        endcase
    end

    // Adders wrap naturally modulo 2^XLEN.
    assign target       = ex_pc + ex_imm;
    assign seq_pc       = ex_pc + XLEN'(4);
    // Illegal encodings resolve as not-taken and never count as mispredicts.
    assign taken_c      = legal & cond;
    assign next_pc_c    = taken_c ? target : seq_pc;
    assign mispredict_c = legal & (taken_c ^ ex_pred_taken);
    assign misaligned_c = taken_c & (target[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Resolution register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_next_pc <= '0;
            mispredict  <= 1'b0;
            misaligned  <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            res_valid  <= accept;
            res_taken  <= accept & taken_c;
            mispredict <= accept & mispredict_c;
            misaligned <= accept & misaligned_c;
            illegal    <= accept & ~legal;
            // The PC is only meaningful alongside res_valid; hold it otherwise.
            if (accept) begin
                res_next_pc <= next_pc_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Branch history table: 2-bit saturating counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CNT_WEAK_NT;
            end
        end else if (accept && legal) begin
            if (taken_c) begin
                if (bht[ex_idx] != CNT_STRONG_T) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'd1;
                end
            end else begin
                if (bht[ex_idx] != CNT_STRONG_NT) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics counters, saturating at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_count <= '0;
            mp_count <= '0;
        end else if (accept && legal) begin
            if (br_count != {CNT_W{1'b1}}) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mispredict_c && (mp_count != {CNT_W{1'b1}})) begin
                mp_count <= mp_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - self-checking bench for branch_unit

module tb_branch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic [31:0] fetch_imm = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic        ex_flush = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_rs1 = '0;
    logic [31:0] ex_rs2 = '0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_imm = '0;
    logic        ex_pred_taken = 1'b0;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_next_pc;
    logic        mispredict;
    logic        misaligned;
    logic        illegal;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    always #5 clk = ~clk;

    branch_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_pc(fetch_pc), .fetch_imm(fetch_imm),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .res_next_pc(res_next_pc),
        .mispredict(mispredict), .misaligned(misaligned), .illegal(illegal),
        .br_count(br_count), .mp_count(mp_count)
    );

    int checks = 0;
    int errors = 0;
    bit started = 0;
    logic pre_pred;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules in plain arithmetic.
    int          bht_m [16];
    bit          m_valid, m_taken, m_mp, m_mis, m_ill, m_legal;
    logic [31:0] m_next, m_tgt;
    longint      m_br, m_mpc;
    int          m_idx;

    function automatic bit cond_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) bht_m[i] = 1;
            m_valid = 0; m_taken = 0; m_mp = 0; m_mis = 0; m_ill = 0;
            m_next = 0; m_br = 0; m_mpc = 0;
        end else begin
            m_valid = ex_valid && !ex_flush;
            m_legal = !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
            m_taken = m_valid && m_legal && cond_of(ex_funct3, ex_rs1, ex_rs2);
            m_tgt   = ex_pc + ex_imm;
            m_ill   = m_valid && !m_legal;
            m_mp    = m_valid && m_legal && (m_taken != ex_pred_taken);
            m_mis   = m_taken && (m_tgt % 4 != 0);
            if (m_valid) m_next = m_taken ? m_tgt : ex_pc + 32'd4;
            if (m_valid && m_legal) begin
                m_idx = int'((ex_pc / 4) % 16);
                if (m_taken) bht_m[m_idx] = (bht_m[m_idx] == 3) ? 3 : bht_m[m_idx] + 1;
                else         bht_m[m_idx] = (bht_m[m_idx] == 0) ? 0 : bht_m[m_idx] - 1;
                m_br++;
                if (m_mp) m_mpc++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_res_valid", {31'd0, res_valid}, {31'd0, m_valid});
            chk("cmp_res_taken", {31'd0, res_taken}, {31'd0, m_taken});
            chk("cmp_mispredict", {31'd0, mispredict}, {31'd0, m_mp});
            chk("cmp_misaligned", {31'd0, misaligned}, {31'd0, m_mis});
            chk("cmp_illegal", {31'd0, illegal}, {31'd0, m_ill});
            if (m_valid) chk("cmp_res_next_pc", res_next_pc, m_next);
            chk("cmp_br_count", br_count, m_br[31:0]);
            chk("cmp_mp_count", mp_count, m_mpc[31:0]);
            chk("cmp_pred_taken", {31'd0, pred_taken},
                {31'd0, bht_m[int'(fetch_pc[5:2])] >= 2});
            chk("cmp_pred_target", pred_target, fetch_pc + fetch_imm);
        end
    end

    // Drive one branch shortly after a falling edge, end on the next falling edge.
    task automatic br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic p, input logic fl);
        #1;
        ex_valid = 1'b1; ex_flush = fl; ex_funct3 = f;
        ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm; ex_pred_taken = p;
        fetch_pc = pc; fetch_imm = imm;
        #1 pre_pred = pred_taken;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        #1 ex_valid = 1'b0; ex_flush = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_next_pc", res_next_pc, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        #1 reset_n = 1'b1;
        started = 1;
        @(negedge clk);

        // BGE not taken: BHT[4] 01 -> 00
        br(3'd5, 32'd2, 32'd4, 32'h10, 32'hFFFF_FFF0, 1'b0, 1'b0);
        chk("bge_valid", {31'd0, res_valid}, 32'd1);
        chk("bge_taken", {31'd0, res_taken}, 32'd0);
        chk("bge_next", res_next_pc, 32'h14);
        chk("bge_mp", {31'd0, mispredict}, 32'd0);
        // One taken update from 00 lands on 01, still predicting not-taken.
        br(3'd0, 32'd3, 32'd3, 32'h10, 32'h8, 1'b0, 1'b0);
        chk("beq10_next", res_next_pc, 32'h18);
        chk("beq10_pred", {31'd0, pred_taken}, 32'd0);

        // Signed vs unsigned with 0xFFFFFFFF / 1
        br(3'd5, 32'hFFFF_FFFF, 32'd1, 32'h108, 32'h20, 1'b0, 1'b0);
        chk("bge_neg_taken", {31'd0, res_taken}, 32'd0);
        chk("bge_neg_next", res_next_pc, 32'h10C);
        br(3'd7, 32'hFFFF_FFFF, 32'd1, 32'h108, 32'h20, 1'b0, 1'b0);
        chk("bgeu_taken", {31'd0, res_taken}, 32'd1);
        chk("bgeu_next", res_next_pc, 32'h128);
        chk("bgeu_mis", {31'd0, misaligned}, 32'd0);
        br(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h108, 32'h20, 1'b0, 1'b0);
        chk("blt_taken", {31'd0, res_taken}, 32'd1);
        br(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h108, 32'h20, 1'b0, 1'b0);
        chk("bltu_taken", {31'd0, res_taken}, 32'd0);
        chk("bltu_next", res_next_pc, 32'h10C);
        chk("step2_br", br_count, 32'd6);
        chk("step2_mp", mp_count, 32'd3);

        // Four taken BEQ at 0x40 back to back, fetch reading the same index
        br(3'd0, 32'd7, 32'd7, 32'h40, 32'h80, 1'b0, 1'b0);
        chk("beq1_prepred", {31'd0, pre_pred}, 32'd0);
        chk("beq1_mp", {31'd0, mispredict}, 32'd1);
        chk("beq1_pred", {31'd0, pred_taken}, 32'd1);
        chk("beq1_next", res_next_pc, 32'hC0);
        br(3'd0, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("beq2_prepred", {31'd0, pre_pred}, 32'd1);
        chk("beq2_mp", {31'd0, mispredict}, 32'd0);
        br(3'd0, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("beq3_mp", {31'd0, mispredict}, 32'd0);
        br(3'd0, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("beq4_mp", {31'd0, mispredict}, 32'd0);
        chk("beq4_pred", {31'd0, pred_taken}, 32'd1);
        chk("beq4_br", br_count, 32'd10);
        chk("beq4_mpc", mp_count, 32'd4);

        // Flush wins over valid; illegal funct3 reports but does not count
        br(3'd0, 32'd1, 32'd2, 32'h40, 32'h80, 1'b1, 1'b1);
        chk("flush_valid", {31'd0, res_valid}, 32'd0);
        chk("flush_br", br_count, 32'd10);
        br(3'd2, 32'd1, 32'd1, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("ill_valid", {31'd0, res_valid}, 32'd1);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_mp", {31'd0, mispredict}, 32'd0);
        chk("ill_next", res_next_pc, 32'h44);
        br(3'd3, 32'd1, 32'd2, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("ill3_flag", {31'd0, illegal}, 32'd1);
        chk("ill_br", br_count, 32'd10);
        chk("ill_mpc", mp_count, 32'd4);

        // Misaligned taken target
        br(3'd1, 32'd1, 32'd2, 32'h200, 32'h2, 1'b0, 1'b0);
        chk("bne_mis", {31'd0, misaligned}, 32'd1);
        chk("bne_next", res_next_pc, 32'h202);
        chk("bne_br", br_count, 32'd11);
        chk("bne_mpc", mp_count, 32'd5);

        // Reset mid-stream discards the in-flight branch
        #1;
        ex_valid = 1'b1; ex_flush = 1'b0; ex_funct3 = 3'd0;
        ex_rs1 = 32'd7; ex_rs2 = 32'd7; ex_pc = 32'h40; ex_imm = 32'h80;
        ex_pred_taken = 1'b1; fetch_pc = 32'h40;
        #2 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_valid", {31'd0, res_valid}, 32'd0);
        chk("mrst_next", res_next_pc, 32'd0);
        chk("mrst_br", br_count, 32'd0);
        chk("mrst_mpc", mp_count, 32'd0);
        chk("mrst_pred", {31'd0, pred_taken}, 32'd0);
        #1 reset_n = 1'b1; ex_valid = 1'b0;
        @(negedge clk);

        br(3'd0, 32'd7, 32'd7, 32'h40, 32'h80, 1'b0, 1'b0);
        chk("post_br", br_count, 32'd1);
        chk("post_mpc", mp_count, 32'd1);
        chk("post_pred", {31'd0, pred_taken}, 32'd1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch resolution and prediction unit for the RV32I core, succeeding the core's fixed single-comparator branch path. It resolves all six B-type conditions (BEQ, BNE, BLT, BGE, BLTU, BGEU) in a registered stage and reports the resolved next PC and any mispredict. It also holds a branch history table (BHT) of 2-bit saturating counters that fetch reads for a taken/not-taken prediction. It sits between the execute stage and the fetch PC mux.

## Interface
- XLEN, 32, datapath and PC width
- BHT_ENTRIES, 16, number of counters; power of two, ≥ 2
- CNT_W, 32, width of the statistics counters
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_pc  in  XLEN  PC of the instruction being fetched
- fetch_imm  in  XLEN  sign-extended B-immediate of the fetched instruction
- pred_taken  out  1  combinational: MSB of BHT[fetch_pc[IDX+1:2]]
- pred_target  out  XLEN  combinational: fetch_pc + fetch_imm
- ex_valid  in  1  a branch is present in execute
- ex_flush  in  1  squash the execute-stage branch
- ex_funct3  in  3  branch condition
- ex_rs1, ex_rs2  in  XLEN  operands
- ex_pc, ex_imm  in  XLEN  branch PC and immediate
- ex_pred_taken  in  1  prediction carried with the instruction
- res_valid  out  1  registered: a resolution is reported this cycle
- res_taken  out  1  registered: the branch was taken
- res_next_pc  out  XLEN  registered: resolved next PC
- mispredict  out  1  registered: res_taken ≠ ex_pred_taken
- misaligned  out  1  registered: taken target with bits [1:0] ≠ 0
- illegal  out  1  registered: funct3 is 010 or 011
- br_count, mp_count  out  CNT_W  resolved-branch and mispredict counters

## Operation
- IDX = log2(BHT_ENTRIES). Fetch indexes the BHT with fetch_pc[IDX+1:2]; resolve uses ex_pc[IDX+1:2].
- Accept condition: ex_valid & ~ex_flush. If false, all res_* flags are 0 the next cycle, and there is no BHT or counter update.
- Conditions by funct3:
  - 000: rs1 == rs2
  - 001: rs1 != rs2
  - 100: signed rs1 < rs2
  - 101: signed rs1 ≥ rs2
  - 110: unsigned rs1 < rs2
  - 111: unsigned rs1 ≥ rs2
- Illegal funct3 (010 or 011):
  - taken = 0, illegal = 1, mispredict = 0, misaligned = 0.
  - No BHT update; br_count does not increment.
  - res_next_pc = ex_pc + 4.
- Next PC: target = ex_pc + ex_imm, modulo 2^XLEN. res_next_pc = taken ? target : ex_pc + 4.
- misaligned = taken & (target[1:0] ≠ 0). mispredict is still computed normally.
- BHT update for accepted legal branches:
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- br_count increments on each accepted legal branch. mp_count increments when mispredict is also set. Both saturate at all-ones.

## Timing
- Resolution latency is 1 cycle: inputs are sampled at edge N, and res_* is valid in the cycle after edge N.
- res_valid is a single-cycle pulse; there is no backpressure.
- Back-to-back branches are accepted every cycle.
- The BHT write takes effect at the resolve edge. A fetch read of the same index in the same cycle returns the pre-update value, with no bypass.
- Reset (asynchronous assert, synchronous-to-clk deassert assumed upstream):
  - All BHT entries = 01 (weakly not-taken).
  - res_valid, res_taken, mispredict, misaligned and illegal = 0.
  - res_next_pc = 0.
  - br_count and mp_count = 0.
  - A reset asserted mid-stream discards the in-flight resolution.
- Simultaneous ex_valid and ex_flush: flush wins.

## Test plan
- BGE, rs1=2, rs2=4, ex_pc=0x10, imm=-0x10, pred=0 → res_taken=0, res_next_pc=0x14, mispredict=0, BHT[4] goes 01→00.
- BGE rs1=0xFFFFFFFF, rs2=1 → not taken. BGEU with the same operands → taken, res_next_pc=ex_pc+imm. BLT and BLTU with the same operands give the inverse results.
- Four consecutive taken BEQ at ex_pc=0x40 (rs1=rs2=7) → BHT[0] goes 01→10→11→11; pred_taken=1 from the second cycle onward; mispredict=1 only on the first (pred=0).
- ex_valid=1 with ex_flush=1, and separately funct3=010 → no BHT change, br_count unchanged; res_valid=0 for the flushed case; illegal=1 for the funct3=010 case.
- Taken BNE with imm=0x2 → misaligned=1, res_next_pc=ex_pc+2; then reset_n pulsed low mid-sequence → all outputs 0, BHT entries read 01, counters 0.
- Resolve and fetch on the same index in the same cycle → pred_taken reflects the old counter; the following cycle reflects the new one.
